// File: rtl/fsm_pattern_serializer.sv
// Frame serializer: optional PAT_LEN-bit preamble then a WIDTH-bit word, MSB first, latency 1.
// Define PATTERN_SERIALIZER_PREAMBLE_EN to compile in the preamble (PRE) phase.
module fsm_pattern_serializer #(
    parameter int          WIDTH   = 8,
    parameter logic [31:0] PAT     = 32'b1101,
    parameter int          PAT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_in,
    output logic             ready_out,
    output logic             d_out,
    output logic             valid_out,
    output logic             done_out
);

    localparam int CNT_MAX = (WIDTH > PAT_LEN) ? WIDTH : PAT_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT_BIT   = CNT_W'(WIDTH - 2);

`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
    localparam logic [CNT_W-1:0]   LAST_PRE = CNT_W'(PAT_LEN - 1);
    localparam logic [PAT_LEN-1:0] PAT_BITS = PAT[PAT_LEN-1:0];

    typedef enum logic [1:0] {IDLE, PRE, SHIFT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             d_out_reg;
    logic             valid_reg;
    logic             done_reg;
    logic             ready_reg;
`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
    logic [PAT_LEN-1:0] pat_reg;
`endif

    // ready_reg is only ever high in IDLE or the final SHIFT cycle, so accept implies a frame boundary.
    logic accept;
    assign accept = load_in && ready_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            d_out_reg <= 1'b0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b0;
`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
            pat_reg   <= '0;
`endif
        end else if (accept) begin
            cnt_reg   <= '0;
            valid_reg <= 1'b1;
            done_reg  <= 1'b0;
            ready_reg <= 1'b0;
`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
            state_reg <= PRE;
            shift_reg <= data_in;
            pat_reg   <= PAT_BITS << 1;
            d_out_reg <= PAT_BITS[PAT_LEN-1];
`else
            state_reg <= SHIFT;
            shift_reg <= data_in << 1;
            d_out_reg <= data_in[WIDTH-1];
`endif
        end else begin
            case (state_reg)
`ifdef PATTERN_SERIALIZER_PREAMBLE_EN
                PRE: begin
                    if (cnt_reg == LAST_PRE) begin
                        state_reg <= SHIFT;
                        cnt_reg   <= '0;
                        d_out_reg <= shift_reg[WIDTH-1];
                        shift_reg <= shift_reg << 1;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        d_out_reg <= pat_reg[PAT_LEN-1];
                        pat_reg   <= pat_reg << 1;
                    end
                end
`endif
                SHIFT: begin
                    if (cnt_reg == LAST_BIT) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        d_out_reg <= 1'b0;
                        valid_reg <= 1'b0;
                        done_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end else begin
                        // done and ready lead by one so they line up with the last bit.
                        cnt_reg   <= cnt_reg + 1'b1;
                        d_out_reg <= shift_reg[WIDTH-1];
                        shift_reg <= shift_reg << 1;
                        done_reg  <= (cnt_reg == PENULT_BIT);
                        ready_reg <= (cnt_reg == PENULT_BIT);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    d_out_reg <= 1'b0;
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ready_out = ready_reg;
    assign d_out     = d_out_reg;
    assign valid_out = valid_reg;
    assign done_out  = done_reg;

endmodule

// File: doc/fsm_pattern_serializer.md
FSM_PATTERN_SERIALIZER -- requirements
Module: fsm_pattern_serializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the payload word width in bits (WIDTH >= 2).
REQ-002 The module SHALL have parameter PAT, default 4'b1101, giving the preamble bit pattern.
REQ-003 The module SHALL have parameter PAT_LEN, default 4, giving the preamble length in bits (1..WIDTH).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port data_in, input, WIDTH bits: the parallel payload word.
REQ-007 The module SHALL have port load_in, input, 1 bit: data_in is valid this cycle.
REQ-008 The module SHALL have port ready_out, output, 1 bit: the serializer accepts a word this cycle.
REQ-009 The module SHALL have port d_out, output, 1 bit: the serial data bit, MSB first.
REQ-010 The module SHALL have port valid_out, output, 1 bit: d_out carries a frame bit this cycle.
REQ-011 The module SHALL have port done_out, output, 1 bit: one-cycle pulse on the last payload bit of a frame.

Function
REQ-012 The module SHALL transmit serial frames onto d_out/valid_out in the format consumed by the team's serial pattern detector (d_in/valid_in).
REQ-013 The FSM SHALL have exactly three states: IDLE, PRE and SHIFT.
REQ-014 A word SHALL be accepted at a rising edge where load_in=1 and ready_out=1; data_in is captured into the shift register at that edge.
REQ-015 A load_in pulse with ready_out=0 SHALL be ignored, with no capture, no state change and no later effect.
REQ-016 In IDLE, ready_out SHALL be 1 and valid_out, done_out and d_out SHALL all be 0.
REQ-017 On acceptance from IDLE, the FSM SHALL move to PRE when the preamble is enabled, otherwise to SHIFT.
REQ-018 PRE SHALL last exactly PAT_LEN cycles with valid_out=1 and d_out=PAT[PAT_LEN-1] down to PAT[0]; the FSM then moves to SHIFT.
REQ-019 SHIFT SHALL last exactly WIDTH cycles with valid_out=1 and d_out = captured word, bit WIDTH-1 down to bit 0.
REQ-020 done_out SHALL be 1 only in the final SHIFT cycle.
REQ-021 ready_out SHALL be 1 in IDLE and in the final SHIFT cycle, and 0 in all other cycles.
REQ-022 An acceptance in the final SHIFT cycle SHALL start the next frame in the immediately following cycle, with no gap in valid_out.
REQ-023 Without an acceptance in the final SHIFT cycle, the FSM SHALL return to IDLE.
REQ-024 The first frame bit SHALL appear in the cycle following the accepting edge (latency 1).
REQ-025 d_out, valid_out and done_out SHALL be driven only from registered state (no combinational path from data_in or load_in).
REQ-026 ready_out SHALL depend only on registered state.
REQ-027 The bit counter SHALL be sized ceil(log2(max(WIDTH, PAT_LEN))) bits and SHALL never wrap within a phase.

Reset
REQ-028 While reset=1, the FSM SHALL be in IDLE, and the shift register, bit counter, d_out, valid_out and done_out SHALL all be 0.
REQ-029 While reset=1, ready_out SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately and asynchronously; no remaining bits and no done_out are emitted.
REQ-031 After reset deasserts, ready_out SHALL be 1 and a word SHALL be accepted at the first qualifying edge.

Configuration
REQ-032 Macro PATTERN_SERIALIZER_PREAMBLE_EN SHALL control the preamble.
REQ-033 With PATTERN_SERIALIZER_PREAMBLE_EN defined, PRE SHALL be compiled in and every frame SHALL be PAT_LEN+WIDTH bits.
REQ-034 Without PATTERN_SERIALIZER_PREAMBLE_EN, PRE and PAT/PAT_LEN logic SHALL be absent, the FSM SHALL go IDLE->SHIFT, and every frame SHALL be WIDTH bits.

Verification
REQ-035 Preamble enabled, defaults, load 8'hA5 once -> d_out = 1,1,0,1,1,0,1,0,0,1,0,1 over 12 consecutive valid_out=1 cycles, done_out on the 12th, then IDLE.
REQ-036 Preamble disabled, load 8'h3C -> d_out = 0,0,1,1,1,1,0,0 over 8 cycles, done_out on the 8th.
REQ-037 Back-to-back 8'hFF then 8'h00, each held with load_in=1 until accepted -> valid_out continuous for 24 cycles (preamble enabled), done_out pulses exactly twice.
REQ-038 load_in=1 with data 8'h81 during PRE/SHIFT of an 8'hA5 frame -> ignored; the serial output matches the A5 frame only.
REQ-039 reset=1 asserted on the 5th bit of a frame -> valid_out=0 asynchronously, no done_out; after release, ready_out=1 and a new 8'h5A frame is sent correctly.
REQ-040 540 random words fed into this block chained to the pattern detector -> detector match count equals a reference-model count of 4'b1101 occurrences (overlapping) in the emitted stream.
